// File: rtl/avalon_keycode_fifo_if.sv
// avalon_keycode_fifo_if: Avalon-MM register bus plus keycode valid/ready stream.
//   slave  modport (FIFO side): takes address/chipselect/write_n/writedata/key_ready,
//                               drives readdata/key_data/key_valid.
//   master modport (CPU + consumer side): the mirror image.
interface avalon_keycode_fifo_if #(parameter int DATA_W = 8);
  logic [1:0]        address;
  logic              chipselect;
  logic              write_n;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [DATA_W-1:0] key_data;
  logic              key_valid;
  logic              key_ready;
  modport slave (
    input  address, chipselect, write_n, writedata, key_ready,
    output readdata, key_data, key_valid
  );
  modport master (
    output address, chipselect, write_n, writedata, key_ready,
    input  readdata, key_data, key_valid
  );
endinterface

// File: rtl/avalon_keycode_fifo.sv
// avalon_keycode_fifo: Avalon-MM written keycode FIFO drained by a valid/ready stream.
//   clk, reset_n (async, active-low)
//   bus      : Avalon slave (address/chipselect/write_n/writedata/readdata) and
//              keycode stream (key_data/key_valid out, key_ready in)
//   out_port : last consumed keycode, held
//   irq      : only when AVALON_KEYCODE_FIFO_IRQ_EN is defined
//   Registers: 0 DATA, 1 STATUS, 2 CONTROL, 3 LAST.
module avalon_keycode_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 8,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  avalon_keycode_fifo_if.slave bus,
  output logic [DATA_W-1:0] out_port
`ifdef AVALON_KEYCODE_FIFO_IRQ_EN
  ,
  output logic              irq
`endif
);
  localparam int PTR_W = $clog2(DEPTH);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] out_port_q, out_port_d, shadow_q, shadow_d;
  logic              enable_q, enable_d, ovf_q, ovf_d, drained_q, drained_d;
  logic              irq_en_q;
  logic              wr, data_wr, status_wr, ctrl_wr, push, pop, flush, full, empty;
  logic [7:0]        cnt8;
  logic              unused;
  assign wr        = bus.chipselect & ~bus.write_n;
  assign data_wr   = wr & (bus.address == 2'd0);
  assign status_wr = wr & (bus.address == 2'd1);
  assign ctrl_wr   = wr & (bus.address == 2'd2);
  assign full      = count_q == CNT_W'(DEPTH);
  assign empty     = count_q == '0;
  // Fullness is judged before any same-cycle pop, so a write into a full FIFO is always lost.
  assign push      = data_wr & ~full;
  assign flush     = ctrl_wr & bus.writedata[1];
  assign bus.key_valid = ~empty & enable_q;
  assign bus.key_data  = mem_q[rd_ptr_q];
  assign pop       = bus.key_valid & bus.key_ready;
  assign out_port  = out_port_q;
  assign cnt8      = 8'(count_q);
  assign unused    = ^bus.writedata;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = bus.writedata[DATA_W-1:0];
    wr_ptr_d   = flush ? '0 : push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = flush ? '0 : pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = flush ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
    out_port_d = pop ? bus.key_data : out_port_q;
    shadow_d   = data_wr ? bus.writedata[DATA_W-1:0] : shadow_q;
    enable_d   = ctrl_wr ? bus.writedata[0] : enable_q;
    // Set terms are OR'd after the W1C mask so a same-cycle set wins.
    ovf_d      = (data_wr & full) | (ovf_q & ~(status_wr & bus.writedata[2]));
    drained_d  = (pop & (count_q == CNT_W'(1)) & ~push) | (drained_q & ~(status_wr & bus.writedata[3]));
  end
  always_comb
    bus.readdata = bus.address == 2'd0 ? 32'(shadow_q) :
                   bus.address == 2'd1 ? {16'b0, cnt8, 4'b0, drained_q, ovf_q, full, empty} :
                   bus.address == 2'd2 ? {29'b0, irq_en_q, 1'b0, enable_q} :
                                         32'(out_port_q);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      out_port_q <= '0;
      shadow_q   <= '0;
      enable_q   <= 1'b0;
      ovf_q      <= 1'b0;
      drained_q  <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      out_port_q <= out_port_d;
      shadow_q   <= shadow_d;
      enable_q   <= enable_d;
      ovf_q      <= ovf_d;
      drained_q  <= drained_d;
    end
`ifdef AVALON_KEYCODE_FIFO_IRQ_EN
  logic irq_en_d, irq_q, irq_d;
  always_comb begin
    irq_en_d = ctrl_wr ? bus.writedata[2] : irq_en_q;
    // Registered from the sticky flops, so irq trails them by one clock.
    irq_d    = irq_en_q & (ovf_q | drained_q);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  assign irq = irq_q;
`else
  assign irq_en_q = 1'b0;
`endif
endmodule

// File: tb/tb_avalon_keycode_fifo.sv
// tb_avalon_keycode_fifo: directed self-checking bench for avalon_keycode_fifo (DATA_W=8, DEPTH=8).
module tb_avalon_keycode_fifo;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [7:0] out_port;
`ifdef AVALON_KEYCODE_FIFO_IRQ_EN
  logic irq;
`endif
  int total = 0;
  int bad = 0;
  avalon_keycode_fifo_if #(.DATA_W(8)) bus ();
  avalon_keycode_fifo #(.DATA_W(8), .DEPTH(8)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus),
    .out_port(out_port)
`ifdef AVALON_KEYCODE_FIFO_IRQ_EN
    ,
    .irq(irq)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address = a;
    bus.writedata = d;
    bus.chipselect = 1'b1;
    bus.write_n = 1'b0;
    tick();
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
  endtask
  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
    bus.address = a;
    bus.chipselect = 1'b1;
    #1;
    chk(tag, bus.readdata, exp);
    bus.chipselect = 1'b0;
  endtask
  initial begin
    bus.address = '0;
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    bus.writedata = '0;
    bus.key_ready = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    rd(2'd0, 32'h0, "rst_data");
    rd(2'd1, 32'h1, "rst_status");
    rd(2'd2, 32'h0, "rst_ctrl");
    rd(2'd3, 32'h0, "rst_last");
    chk("rst_valid", 32'(bus.key_valid), 32'h0);
    chk("rst_out", 32'(out_port), 32'h0);
    chk("rst_kdata", 32'(bus.key_data), 32'h0);
    wr(2'd2, 32'h1);
    wr(2'd0, 32'h04);
    chk("lat_valid", 32'(bus.key_valid), 32'h1);
    wr(2'd0, 32'h1A);
    wr(2'd0, 32'h16);
    rd(2'd1, 32'h0300, "three_status");
    rd(2'd0, 32'h16, "shadow");
    bus.key_ready = 1'b1;
    chk("kd0", 32'(bus.key_data), 32'h04);
    tick();
    chk("kd1", 32'(bus.key_data), 32'h1A);
    chk("out1", 32'(out_port), 32'h04);
    tick();
    chk("kd2", 32'(bus.key_data), 32'h16);
    tick();
    bus.key_ready = 1'b0;
    chk("out3", 32'(out_port), 32'h16);
    chk("valid_after_drain", 32'(bus.key_valid), 32'h0);
    rd(2'd1, 32'h0009, "drained_status");
    rd(2'd3, 32'h16, "last");
    wr(2'd1, 32'h8);
    rd(2'd1, 32'h0001, "w1c_drained");
    wr(2'd2, 32'h0);
    for (int i = 1; i <= 9; i++) wr(2'd0, 32'(i));
    rd(2'd1, 32'h0806, "ovf_status");
    chk("disabled_valid", 32'(bus.key_valid), 32'h0);
    wr(2'd2, 32'h1);
    bus.key_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain%0d", i), 32'(bus.key_data), 32'(i));
      tick();
    end
    bus.key_ready = 1'b0;
    chk("drain_out", 32'(out_port), 32'h08);
    rd(2'd1, 32'h000D, "drain_status");
    wr(2'd1, 32'h4);
    rd(2'd1, 32'h0009, "w1c_ovf");
    wr(2'd1, 32'h8);
    wr(2'd2, 32'h0);
    for (int i = 0; i < 8; i++) wr(2'd0, 32'h20 + 32'(i));
    rd(2'd1, 32'h0802, "full_status");
    wr(2'd2, 32'h1);
    bus.key_ready = 1'b1;
    wr(2'd0, 32'h55);
    bus.key_ready = 1'b0;
    rd(2'd1, 32'h0704, "pushpop_status");
    chk("pushpop_out", 32'(out_port), 32'h20);
    bus.key_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("wrap%0d", i), 32'(bus.key_data), 32'h20 + 32'(i));
      tick();
    end
    bus.key_ready = 1'b0;
    chk("wrap_out", 32'(out_port), 32'h27);
    rd(2'd1, 32'h000D, "wrap_status");
    wr(2'd1, 32'hC);
    rd(2'd1, 32'h0001, "w1c_both");
    for (int i = 0; i < 5; i++) wr(2'd0, 32'h31 + 32'(i));
    rd(2'd1, 32'h0500, "five_status");
    wr(2'd2, 32'h3);
    rd(2'd1, 32'h0001, "flush_status");
    chk("flush_valid", 32'(bus.key_valid), 32'h0);
    chk("flush_out", 32'(out_port), 32'h27);
    rd(2'd2, 32'h1, "flush_ctrl");
    wr(2'd0, 32'h2C);
    chk("post_flush_valid", 32'(bus.key_valid), 32'h1);
    chk("post_flush_kdata", 32'(bus.key_data), 32'h2C);
    wr(2'd2, 32'h0);
    chk("disable_valid", 32'(bus.key_valid), 32'h0);
    rd(2'd1, 32'h0100, "retained_status");
`ifdef AVALON_KEYCODE_FIFO_IRQ_EN
    wr(2'd2, 32'h5);
    rd(2'd2, 32'h5, "ctrl_irq_en");
    chk("irq_idle", 32'(irq), 32'h0);
    bus.key_ready = 1'b1;
    tick();
    bus.key_ready = 1'b0;
    chk("irq_not_yet", 32'(irq), 32'h0);
    tick();
    chk("irq_set", 32'(irq), 32'h1);
    wr(2'd1, 32'h8);
    tick();
    chk("irq_clr", 32'(irq), 32'h0);
`else
    wr(2'd2, 32'h4);
    rd(2'd2, 32'h0, "ctrl_bit2_ignored");
    wr(2'd2, 32'h5);
    rd(2'd2, 32'h1, "ctrl_bit2_masked");
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
